// File: rtl/fft_bfly_pipe.sv
// fft_bfly_pipe: 3-stage radix-2 DIT butterfly, y0 = a + b*w, y1 = a - b*w.
// Define BFLY_SAT_EN to clamp out-of-range results instead of wrapping them.
module fft_bfly_pipe #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_re,
  input  logic [DATA_W-1:0] a_im,
  input  logic [DATA_W-1:0] b_re,
  input  logic [DATA_W-1:0] b_im,
  input  logic [TW_W-1:0]   w_re,
  input  logic [TW_W-1:0]   w_im,
  input  logic              inv,
  input  logic              scale,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y0_re,
  output logic [DATA_W-1:0] y0_im,
  output logic [DATA_W-1:0] y1_re,
  output logic [DATA_W-1:0] y1_im,
  output logic              ovf,
  output logic [TAG_W-1:0]  tag_out
);

  localparam int PW = DATA_W + TW_W;
  localparam int SW = PW + 1;
  localparam int BW = DATA_W + 2;
  localparam int YW = DATA_W + 3;

  localparam logic signed [SW-1:0] RND =
    {{(SW-TW_W+1){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};

`ifdef BFLY_SAT_EN
  localparam logic [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  logic en;

  // Stage 1 state
  logic                     v1_q;
  logic signed [DATA_W-1:0] ar1_q, ai1_q;
  logic [TAG_W-1:0]         tag1_q;
  logic                     inv1_q, scl1_q;
  logic signed [PW-1:0]     prr_q, pii_q, pri_q, pir_q;

  // Stage 2 state
  logic                     v2_q;
  logic signed [DATA_W-1:0] ar2_q, ai2_q;
  logic [TAG_W-1:0]         tag2_q;
  logic                     scl2_q;
  logic signed [BW-1:0]     bwr2_q, bwi2_q;

  // Stage 3 (output) state
  logic                     v3_q;
  logic [DATA_W-1:0]        y0r_q, y0i_q, y1r_q, y1i_q;
  logic                     ovf_q;
  logic [TAG_W-1:0]         tag3_q;

  assign en       = !v3_q | out_ready;
  assign in_ready = en;

  // Stage 1 next state: full-width products
  logic signed [PW-1:0] bre_x, bim_x, wre_x, wim_x;
  logic signed [PW-1:0] prr_d, pii_d, pri_d, pir_d;

  assign bre_x = PW'($signed(b_re));
  assign bim_x = PW'($signed(b_im));
  assign wre_x = PW'($signed(w_re));
  assign wim_x = PW'($signed(w_im));

  assign prr_d = bre_x * wre_x;
  assign pii_d = bim_x * wim_x;
  assign pri_d = bre_x * wim_x;
  assign pir_d = bim_x * wre_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      ar1_q  <= '0;
      ai1_q  <= '0;
      tag1_q <= '0;
      inv1_q <= 1'b0;
      scl1_q <= 1'b0;
      prr_q  <= '0;
      pii_q  <= '0;
      pri_q  <= '0;
      pir_q  <= '0;
    end else if (en) begin
      v1_q   <= in_valid;
      ar1_q  <= $signed(a_re);
      ai1_q  <= $signed(a_im);
      tag1_q <= tag_in;
      inv1_q <= inv;
      scl1_q <= scale;
      prr_q  <= prr_d;
      pii_q  <= pii_d;
      pri_q  <= pri_d;
      pir_q  <= pir_d;
    end
  end

  // Stage 2 next state: combine, round half-up, drop TW_W-1 fraction bits
  logic signed [SW-1:0] sre_d, sim_d, rre_d, rim_d;
  logic signed [BW-1:0] bwr_d, bwi_d;
  logic                 unused_frac;

  always_comb begin
    sre_d = '0;
    sim_d = '0;
    if (inv1_q) begin
      sre_d = SW'(prr_q) + SW'(pii_q);
      sim_d = SW'(pir_q) - SW'(pri_q);
    end else begin
      sre_d = SW'(prr_q) - SW'(pii_q);
      sim_d = SW'(pri_q) + SW'(pir_q);
    end
  end

  assign rre_d = sre_d + RND;
  assign rim_d = sim_d + RND;
  assign bwr_d = rre_d[TW_W-1 +: BW];
  assign bwi_d = rim_d[TW_W-1 +: BW];

  assign unused_frac = ^{rre_d[TW_W-2:0], rim_d[TW_W-2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q   <= 1'b0;
      ar2_q  <= '0;
      ai2_q  <= '0;
      tag2_q <= '0;
      scl2_q <= 1'b0;
      bwr2_q <= '0;
      bwi2_q <= '0;
    end else if (en) begin
      v2_q   <= v1_q;
      ar2_q  <= ar1_q;
      ai2_q  <= ai1_q;
      tag2_q <= tag1_q;
      scl2_q <= scl1_q;
      bwr2_q <= bwr_d;
      bwi2_q <= bwi_d;
    end
  end

  // Stage 3 helpers
  function automatic logic signed [YW-1:0] fin(
    input logic signed [DATA_W-1:0] a,
    input logic signed [BW-1:0]     b,
    input logic                     sub,
    input logic                     sc
  );
    logic signed [YW-1:0] s;
    logic signed [YW-1:0] t;
    s = sub ? (YW'(a) - YW'(b)) : (YW'(a) + YW'(b));
    t = s + YW'(1);
    return sc ? (t >>> 1) : s;
  endfunction

  function automatic logic ovr(input logic signed [YW-1:0] v);
    logic [YW-DATA_W:0] top;
    top = v[YW-1:DATA_W-1];
    return !((&top) | ~(|top));
  endfunction

  function automatic logic [DATA_W-1:0] red(input logic signed [YW-1:0] v);
`ifdef BFLY_SAT_EN
    if (ovr(v)) return v[YW-1] ? DMIN : DMAX;
`endif
    return v[DATA_W-1:0];
  endfunction

  logic signed [YW-1:0] y0r_w, y0i_w, y1r_w, y1i_w;
  logic                 ovf_d;

  assign y0r_w = fin(ar2_q, bwr2_q, 1'b0, scl2_q);
  assign y0i_w = fin(ai2_q, bwi2_q, 1'b0, scl2_q);
  assign y1r_w = fin(ar2_q, bwr2_q, 1'b1, scl2_q);
  assign y1i_w = fin(ai2_q, bwi2_q, 1'b1, scl2_q);

  // Gate with valid so bubble data never raises the flag
  assign ovf_d = v2_q & (ovr(y0r_w) | ovr(y0i_w) |
                         ovr(y1r_w) | ovr(y1i_w));

  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q   <= 1'b0;
      y0r_q  <= '0;
      y0i_q  <= '0;
      y1r_q  <= '0;
      y1i_q  <= '0;
      ovf_q  <= 1'b0;
      tag3_q <= '0;
    end else if (en) begin
      v3_q   <= v2_q;
      y0r_q  <= red(y0r_w);
      y0i_q  <= red(y0i_w);
      y1r_q  <= red(y1r_w);
      y1i_q  <= red(y1i_w);
      ovf_q  <= ovf_d;
      tag3_q <= tag2_q;
    end
  end

  assign out_valid = v3_q;
  assign y0_re     = y0r_q;
  assign y0_im     = y0i_q;
  assign y1_re     = y1r_q;
  assign y1_im     = y1i_q;
  assign ovf       = ovf_q;
  assign tag_out   = tag3_q;

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// tb_fft_bfly_pipe: directed and model-checked stimulus for fft_bfly_pipe.
// Expected overflow value of y0_re follows BFLY_SAT_EN.
module tb_fft_bfly_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, in_valid, in_ready;
  logic signed [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic              inv, scale;
  logic [7:0]        tag_in;
  logic              out_valid, out_ready;
  logic signed [15:0] y0_re, y0_im, y1_re, y1_im;
  logic              ovf;
  logic [7:0]        tag_out;

  fft_bfly_pipe #(.DATA_W(16), .TW_W(16), .TAG_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im), .inv(inv), .scale(scale),
    .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
    .ovf(ovf), .tag_out(tag_out)
  );

`ifdef BFLY_SAT_EN
  localparam int OVF_Y0 = 32767;
`else
  localparam int OVF_Y0 = -5537;
`endif
  localparam int NRND = 10000;

  typedef struct packed {
    logic [15:0] y0r, y0i, y1r, y1i;
    logic        ovf;
    logic [7:0]  tag;
  } res_t;

  int checks = 0;
  int failures = 0;
  res_t exp_q[$];

  task automatic chk(input string nm,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp);
    end
  endtask

  function automatic logic [15:0] reduce(input longint v);
`ifdef BFLY_SAT_EN
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  function automatic res_t model(input int ar, ai, br, bi, wr, wi,
                                 input bit iv, sc, input logic [7:0] tg);
    longint prr, pii, pri, pir, sre, sim, bre, bim;
    longint y[4];
    res_t r;
    prr = longint'(br) * wr;
    pii = longint'(bi) * wi;
    pri = longint'(br) * wi;
    pir = longint'(bi) * wr;
    sre = iv ? prr + pii : prr - pii;
    sim = iv ? pir - pri : pri + pir;
    bre = (sre + 16384) >>> 15;
    bim = (sim + 16384) >>> 15;
    y[0] = ar + bre;
    y[1] = ai + bim;
    y[2] = ar - bre;
    y[3] = ai - bim;
    r.ovf = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (sc) y[k] = (y[k] + 1) >>> 1;
      if (y[k] > 32767 || y[k] < -32768) r.ovf = 1'b1;
    end
    r.y0r = reduce(y[0]);
    r.y0i = reduce(y[1]);
    r.y1r = reduce(y[2]);
    r.y1i = reduce(y[3]);
    r.tag = tg;
    return r;
  endfunction

  task automatic drive(input int ar, ai, br, bi, wr, wi,
                       input bit iv, sc, input logic [7:0] tg);
    a_re = 16'(ar); a_im = 16'(ai);
    b_re = 16'(br); b_im = 16'(bi);
    w_re = 16'(wr); w_im = 16'(wi);
    inv = iv; scale = sc; tag_in = tg;
  endtask

  task automatic run_beat(input string nm,
                          input int ar, ai, br, bi, wr, wi,
                          input bit iv, sc, input logic [7:0] tg,
                          input int e0r, e0i, e1r, e1i,
                          input bit eo);
    @(negedge clk);
    drive(ar, ai, br, bi, wr, wi, iv, sc, tg);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 chk({nm, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, "_lat1"}, out_valid, 0);
    @(negedge clk);
    chk({nm, "_lat2"}, out_valid, 0);
    @(negedge clk);
    chk({nm, "_lat3"}, out_valid, 1);
    chk({nm, "_y0re"}, y0_re, e0r);
    chk({nm, "_y0im"}, y0_im, e0i);
    chk({nm, "_y1re"}, y1_re, e1r);
    chk({nm, "_y1im"}, y1_im, e1i);
    chk({nm, "_ovf"}, ovf, eo);
    chk({nm, "_tag"}, tag_out, tg);
  endtask

  initial begin
    int sent, got, acc, cyc;
    bit stall_prev;
    logic signed [15:0] hold_y;
    logic [7:0] hold_t;
    res_t o, e;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_y0re", y0_re, 0);
    chk("rst_tag", tag_out, 0);

    run_beat("real", 1000, 0, 500, 0, 32767, 0, 0, 0, 8'h11,
             1500, 0, 500, 0, 0);
    run_beat("jrot", 0, 0, 0, 1000, 0, 32767, 0, 0, 8'h22,
             -1000, 0, 1000, 0, 0);
    run_beat("jinv", 0, 0, 0, 1000, 0, 32767, 1, 0, 8'h33,
             1000, 0, -1000, 0, 0);
    run_beat("ovf", 30000, 0, 30000, 0, 32767, 0, 0, 0, 8'h44,
             OVF_Y0, 0, 1, 0, 1);
    run_beat("ovfsc", 30000, 0, 30000, 0, 32767, 0, 0, 1, 8'h55,
             30000, 0, 1, 0, 0);
    run_beat("wneg1", 0, 0, 1000, 0, -32768, 0, 0, 0, 8'h66,
             -1000, 0, 1000, 0, 0);

    // Backpressure: six beats, out_ready low for cycles 2..6
    sent = 0;
    got = 0;
    stall_prev = 1'b0;
    hold_y = '0;
    hold_t = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = (sent < 6);
      drive(sent * 10, 0, 0, 0, 0, 0, 0, 0, 8'(sent));
      out_ready = !(c >= 2 && c < 7);
      #1;
      if (stall_prev) begin
        chk("bp_hold_y", y0_re, hold_y);
        chk("bp_hold_tag", tag_out, hold_t);
      end
      if (out_valid && !out_ready) begin
        chk("bp_in_ready", in_ready, 0);
        stall_prev = 1'b1;
        hold_y = y0_re;
        hold_t = tag_out;
      end else begin
        stall_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        chk("bp_tag", tag_out, got);
        chk("bp_data", y0_re, got * 10);
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    chk("bp_count", got, 6);

    // Reset with three beats in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      drive(100 + i, 7, 0, 0, 0, 0, 0, 0, 8'(8'hA0 + i));
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_y0re", y0_re, 0);
    chk("mrst_y0im", y0_im, 0);
    chk("mrst_tag", tag_out, 0);
    chk("mrst_ovf", ovf, 0);
    chk("mrst_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mrst_no_stale", out_valid, 0);
    end
    run_beat("fresh", 1234, -321, 0, 0, 0, 0, 0, 0, 8'h77,
             1234, -321, 1234, -321, 0);

    // Random traffic against the reference model
    acc = 0;
    cyc = 0;
    while ((acc < NRND || exp_q.size() != 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      in_valid = (acc < NRND) && ($urandom_range(3) != 0);
      a_re = 16'($urandom());
      a_im = 16'($urandom());
      b_re = 16'($urandom());
      b_im = 16'($urandom());
      w_re = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom());
      w_im = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom());
      inv = 1'($urandom());
      scale = 1'($urandom());
      tag_in = 8'($urandom());
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_extra_beat", 1, 0);
        end else begin
          o = {y0_re, y0_im, y1_re, y1_im, ovf, tag_out};
          e = exp_q.pop_front();
          checks++;
          assert (o === e) else begin
            failures++;
            $error("FAIL rnd_beat observed=%h expected=%h", o, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a_re, a_im, b_re, b_im, w_re, w_im,
                              inv, scale, tag_in));
        acc++;
      end
    end
    chk("rnd_accepted", acc, NRND);
    chk("rnd_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_bfly_pipe.md
Name: fft_bfly_pipe

Overview:
- Next-generation radix-2 DIT butterfly for the FFT datapath: y0 = a + b·w, y1 = a − b·w.
- Parametrised signed fixed-point complex data. Replaces the combinational IEEE-754 butterfly.
- 3-stage pipeline with valid/ready handshake and backpressure.
- Per-beat features: inverse mode (conjugate twiddle), optional 1/2 scaling, overflow flag, sideband tag.
- Sits between the FFT stage sample memory and the twiddle ROM.

Parameters:
- DATA_W, 16: width of each real/imag data component, two's complement.
- TW_W, 16: width of each twiddle component, signed Q1.(TW_W−1).
- TAG_W, 8: width of the sideband tag carried alongside each beat (sample index/channel).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a_re, a_im  in  DATA_W each  operand a.
- b_re, b_im  in  DATA_W each  operand b.
- w_re, w_im  in  TW_W each  twiddle.
- inv  in  1  1 = use conj(w) (IFFT).
- scale  in  1  1 = divide both outputs by 2 with rounding.
- tag_in  in  TAG_W  sideband, returned unmodified.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- y0_re, y0_im, y1_re, y1_im  out  DATA_W each  results.
- ovf  out  1  this beat's result clipped/wrapped in any component.
- tag_out  out  TAG_W  tag of this beat.

Behaviour:
- Pipeline advance: en = !out_valid | out_ready; in_ready = en (combinational). Beat accepted when in_valid & in_ready.
- When en = 0, all stages hold, including bubbles. No bubble collapsing.
- Latency: exactly 3 cycles from acceptance to out_valid when unstalled. Throughput 1 beat/cycle. Order preserved.
- S1: register a, tag, inv, scale. Register 4 full-width products (DATA_W+TW_W bits each): br·wr, bi·wi, br·wi, bi·wr.
- S2: combine products.
  - inv = 0: bw_re = p_rr − p_ii, bw_im = p_ri + p_ir.
  - inv = 1: bw_re = p_rr + p_ii, bw_im = p_ir − p_ri.
  - Width DATA_W+TW_W+1, no overflow possible.
  - Round half-up: add 2^(TW_W−2), then arithmetic shift right by TW_W−1. Keep DATA_W+2 bits.
- S3: sums y0 = a + bw, y1 = a − bw at DATA_W+3 bits.
  - If scale: add 1, then arithmetic shift right 1.
  - Reduce each component to DATA_W per the feature below.
  - ovf = OR over the 4 components of (value outside [−2^(DATA_W−1), 2^(DATA_W−1)−1]).
- Reset: out_valid = 0, ovf = 0, all outputs and pipeline data = 0, internal valids = 0. A reset mid-stream discards in-flight beats; none emerge after reset. in_ready = 1 the cycle after reset is released.
- Outputs stay stable while out_valid & !out_ready.
- Twiddle −1.0 (−2^(TW_W−1)) is legal. +1.0 is not representable; software uses 2^(TW_W−1)−1.
- X on data while in_valid = 0 must not propagate to out_valid or ovf.

Optional Feature:
- Macro: BFLY_SAT_EN.
- Defined: out-of-range components clamp to 2^(DATA_W−1)−1 or −2^(DATA_W−1).
- Undefined: out-of-range components wrap (keep low DATA_W bits).
- ovf asserts identically in both builds.

Test Plan (DATA_W = TW_W = 16):
- Real multiply: a=(1000,0), b=(500,0), w=(32767,0), inv=0, scale=0, out_ready=1 -> 3 cycles later y0=(1500,0), y1=(500,0), ovf=0, tag matches.
- j-rotation and inv: a=(0,0), b=(0,1000), w=(0,32767).
  - inv=0 -> y0=(−1000,0), y1=(1000,0).
  - Same beat with inv=1 -> y0=(1000,0), y1=(−1000,0).
- Overflow: a=(30000,0), b=(30000,0), w=(32767,0), scale=0.
  - y1_re=1, ovf=1.
  - y0_re=32767 with BFLY_SAT_EN; y0_re=−5537 without.
  - Same beat with scale=1 -> y0_re=30000, y1_re=1, ovf=0.
- Backpressure: stream 6 beats (tags 0–5) with out_ready held low from cycle 2 for 5 cycles.
  - in_ready drops while out_valid & !out_ready.
  - Outputs hold stable.
  - All 6 beats emerge in tag order, no duplicates or loss.
- Reset mid-stream: 3 beats in flight, assert rst 1 cycle -> out_valid=0 next cycle, outputs 0, no stale beat appears. A fresh beat afterwards has latency 3.
- Random: 10k beats with random data, twiddles, inv, scale and out_ready, checked against a bit-exact reference model (rounding, ovf, tags).
